mem_access_sequencer: RTL

Sequences all accesses to the single-port instruction/data memory bus of the rv32 core. It arbitrates between the fetch stage and the load/store path, which is driven by the control logic unit's `read_mem`/`write_mem`/`load_byte`/`store_byte` signals. It generates byte lanes for `sb`/`lb`, sign-extends byte loads and asserts a pipeline stall until the data-side access retires. It sits between the core datapath and the external memory bus.

---
 rtl/mem_access_sequencer.sv | 190 +++++++++++++++++++
 1 files changed

// File: rtl/mem_access_sequencer.sv
// Single-port memory bus sequencer for the rv32 core: data-over-fetch arbitration, byte lanes,
// sign-extended byte loads and stall. Define MEM_TIMEOUT_EN to enable the bus_ready timeout.
module mem_access_sequencer #(
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              nrst,
    input  logic              fetch_req,
    input  logic [ADDR_W-1:0] fetch_addr,
    output logic              fetch_ack,
    output logic [31:0]       fetch_data,
    input  logic              read_mem,
    input  logic              write_mem,
    input  logic              load_byte,
    input  logic              store_byte,
    input  logic [ADDR_W-1:0] data_addr,
    input  logic [31:0]       data_wdata,
    output logic              data_ack,
    output logic [31:0]       data_rdata,
    output logic              data_err,
    output logic              stall,
    output logic [ADDR_W-1:0] bus_addr,
    output logic              bus_read,
    output logic              bus_write,
    output logic [3:0]        bus_sel,
    output logic [31:0]       bus_wdata,
    input  logic [31:0]       bus_rdata,
    input  logic              bus_ready
);

    typedef enum logic [2:0] {StIdle, StFetch, StDread, StDwrite, StResp} state_e;

    localparam logic [31:0] FetchNop = 32'h0000_0013;

    state_e            state_q;
    logic [ADDR_W-1:0] bus_addr_q;
    logic              bus_read_q;
    logic              bus_write_q;
    logic [3:0]        bus_sel_q;
    logic [31:0]       bus_wdata_q;
    logic              fetch_ack_q;
    logic [31:0]       fetch_data_q;
    logic              data_ack_q;
    logic              data_err_q;
    logic [31:0]       data_rdata_q;
    logic              byte_q;
    logic [1:0]        off_q;

`ifdef MEM_TIMEOUT_EN
    localparam int unsigned CntW = $clog2(TIMEOUT + 1);
    logic [CntW-1:0] cnt_q;
    logic            timeout_hit;
    assign timeout_hit = (cnt_q == CntW'(TIMEOUT - 1));
`endif

    logic       data_req;
    logic       req_byte;
    logic       misaligned;
    logic [7:0] rd_byte;

    always_comb begin
        data_req   = read_mem | write_mem;
        // Write wins a simultaneous read, so its qualifier decides the access size.
        req_byte   = write_mem ? store_byte : load_byte;
        misaligned = data_req & ~req_byte & (data_addr[1:0] != 2'b00);
        rd_byte    = bus_rdata[{off_q, 3'b000} +: 8];
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q      <= StIdle;
            bus_addr_q   <= '0;
            bus_read_q   <= 1'b0;
            bus_write_q  <= 1'b0;
            bus_sel_q    <= 4'b0000;
            bus_wdata_q  <= 32'h0;
            fetch_ack_q  <= 1'b0;
            fetch_data_q <= 32'h0;
            data_ack_q   <= 1'b0;
            data_err_q   <= 1'b0;
            data_rdata_q <= 32'h0;
            byte_q       <= 1'b0;
            off_q        <= 2'b00;
`ifdef MEM_TIMEOUT_EN
            cnt_q        <= '0;
`endif
        end else begin
            fetch_ack_q <= 1'b0;
            data_ack_q  <= 1'b0;
            data_err_q  <= 1'b0;
            unique case (state_q)
                StIdle: begin
`ifdef MEM_TIMEOUT_EN
                    cnt_q <= '0;
`endif
                    if (misaligned) begin
                        state_q    <= StResp;
                        data_ack_q <= 1'b1;
                        data_err_q <= 1'b1;
                    end else if (write_mem) begin
                        state_q     <= StDwrite;
                        bus_write_q <= 1'b1;
                        bus_addr_q  <= {data_addr[ADDR_W-1:2], 2'b00};
                        byte_q      <= store_byte;
                        off_q       <= data_addr[1:0];
                        if (store_byte) begin
                            bus_sel_q   <= 4'b0001 << data_addr[1:0];
                            bus_wdata_q <= {4{data_wdata[7:0]}};
                        end else begin
                            bus_sel_q   <= 4'b1111;
                            bus_wdata_q <= data_wdata;
                        end
                    end else if (read_mem) begin
                        state_q    <= StDread;
                        bus_read_q <= 1'b1;
                        bus_addr_q <= {data_addr[ADDR_W-1:2], 2'b00};
                        bus_sel_q  <= 4'b1111;
                        byte_q     <= load_byte;
                        off_q      <= data_addr[1:0];
                    end else if (fetch_req) begin
                        state_q    <= StFetch;
                        bus_read_q <= 1'b1;
                        bus_addr_q <= {fetch_addr[ADDR_W-1:2], 2'b00};
                        bus_sel_q  <= 4'b1111;
                    end
                end
                StFetch, StDread, StDwrite: begin
                    if (bus_ready) begin
                        state_q     <= StResp;
                        bus_read_q  <= 1'b0;
                        bus_write_q <= 1'b0;
                        bus_sel_q   <= 4'b0000;
                        if (state_q == StFetch) begin
                            fetch_ack_q  <= 1'b1;
                            fetch_data_q <= bus_rdata;
                        end else begin
                            data_ack_q <= 1'b1;
                            if (state_q == StDread) begin
                                data_rdata_q <= byte_q ? {{24{rd_byte[7]}}, rd_byte} : bus_rdata;
                            end
                        end
`ifdef MEM_TIMEOUT_EN
                        cnt_q <= '0;
                    end else if (timeout_hit) begin
                        state_q     <= StResp;
                        bus_read_q  <= 1'b0;
                        bus_write_q <= 1'b0;
                        bus_sel_q   <= 4'b0000;
                        cnt_q       <= '0;
                        if (state_q == StFetch) begin
                            fetch_ack_q  <= 1'b1;
                            fetch_data_q <= FetchNop;
                        end else begin
                            data_ack_q <= 1'b1;
                            data_err_q <= 1'b1;
                        end
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
`endif
                    end
                end
                StResp: begin
                    state_q <= StIdle;
`ifdef MEM_TIMEOUT_EN
                    cnt_q   <= '0;
`endif
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign stall      = data_req & ~data_ack_q;
    assign bus_addr   = bus_addr_q;
    assign bus_read   = bus_read_q;
    assign bus_write  = bus_write_q;
    assign bus_sel    = bus_sel_q;
    assign bus_wdata  = bus_wdata_q;
    assign fetch_ack  = fetch_ack_q;
    assign fetch_data = fetch_data_q;
    assign data_ack   = data_ack_q;
    assign data_err   = data_err_q;
    assign data_rdata = data_rdata_q;

    // Fetches are word-granular; TIMEOUT is only consumed by the timeout build.
    logic unused_bits;
    assign unused_bits = ^{fetch_addr[1:0], FetchNop[0], TIMEOUT};

endmodule
